// File: rtl/result_collector.sv
// -----------------------------------------------------------------------------
// result_collector
//
// Collects an m x m matrix of 32-bit results from a strobe-driven producer
// (typically a matrix multiplier) and provides two combinational read ports.
//
// Handshake: the producer raises z_stb with z_out/z_i/z_j stable. The
// collector samples it on a rising edge in COLLECT, answers with a one-cycle
// z_ack in the following cycle (ACK), and ignores z_stb during that ACK
// cycle. The producer drops z_stb after seeing z_ack. The earliest next
// acceptance is therefore two edges after the previous one.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               starts/restarts a collection (honoured in IDLE/FULL)
//   z_out, z_i, z_j     result value and its row/column
//   z_stb / z_ack       producer strobe / one-cycle acknowledge
//   cur_i, cur_j        index for current_element (combinational read)
//   r_i, r_j            writer read index, m_len+1 bits; out of range reads 0
//   r_value             combinational read data for [r_i][r_j]
//   done                high in FULL (all m*m entries written since start)
//   idx_err             sticky: strobe with out-of-range index
//   dup_err             sticky: in-range write to an already-valid entry
//   state_o, count_o    debug view of FSM state and written-entry count
//
// Optional feature: define RESULT_COLLECTOR_DUP_DETECT_EN to enable the
// duplicate-write detector; otherwise dup_err is tied to 0.
// -----------------------------------------------------------------------------
module result_collector #(
    parameter int m     = 4,
    parameter int m_len = $clog2(m)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       z_out,
    input  logic [m_len-1:0]  z_i,
    input  logic [m_len-1:0]  z_j,
    input  logic              z_stb,
    output logic              z_ack,
    input  logic [m_len-1:0]  cur_i,
    input  logic [m_len-1:0]  cur_j,
    output logic [31:0]       current_element,
    input  logic [m_len:0]    r_i,
    input  logic [m_len:0]    r_j,
    output logic [31:0]       r_value,
    output logic              done,
    output logic              idx_err,
    output logic              dup_err,
    output logic [1:0]        state_o,
    output logic [2*m_len:0]  count_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_FULL    = 2'd3;

    localparam logic [m_len:0]   M_EXT    = (m_len + 1)'(m);
    localparam logic [2*m_len:0] FULL_CNT = (2 * m_len + 1)'(m * m);

    logic [1:0]       state_q, state_d;
    logic [2*m_len:0] count_q, count_d;
    logic             idx_err_q, idx_err_d;
    logic [31:0]      mem_q   [m][m];
    logic             valid_q [m][m];

    logic z_in_range;
    logic clear;
    logic accept;
    logic wr_en;
    logic was_valid;

    // Index checks are done one bit wider so that m itself is representable.
    assign z_in_range = ({1'b0, z_i} < M_EXT) && ({1'b0, z_j} < M_EXT);
    assign clear      = ((state_q == S_IDLE) || (state_q == S_FULL)) && start;
    assign accept     = (state_q == S_COLLECT) && z_stb;
    assign wr_en      = accept && z_in_range;

    always_comb begin
        was_valid = 1'b0;
        if (z_in_range) begin
            was_valid = valid_q[z_i][z_j];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_COLLECT;
            S_COLLECT: if (z_stb) state_d = S_ACK;
            S_ACK:     state_d = (count_q == FULL_CNT) ? S_FULL : S_COLLECT;
            S_FULL:    if (start) state_d = S_COLLECT;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        idx_err_d = idx_err_q;
        if (clear) begin
            count_d   = '0;
            idx_err_d = 1'b0;
        end else if (accept) begin
            if (!z_in_range) begin
                idx_err_d = 1'b1;
            end else if (!was_valid) begin
                // Rewrites of a valid entry do not advance the count.
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            idx_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_err_q <= idx_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < m; a++) begin
                for (int b = 0; b < m; b++) begin
                    mem_q[a][b]   <= '0;
                    valid_q[a][b] <= 1'b0;
                end
            end
        end else if (clear) begin
            for (int a = 0; a < m; a++) begin
                for (int b = 0; b < m; b++) begin
                    mem_q[a][b]   <= '0;
                    valid_q[a][b] <= 1'b0;
                end
            end
        end else if (wr_en) begin
            mem_q[z_i][z_j]   <= z_out;
            valid_q[z_i][z_j] <= 1'b1;
        end
    end

`ifdef RESULT_COLLECTOR_DUP_DETECT_EN
    logic dup_err_q, dup_err_d;

    always_comb begin
        dup_err_d = dup_err_q;
        if (clear) begin
            dup_err_d = 1'b0;
        end else if (wr_en && was_valid) begin
            dup_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dup_err_q <= 1'b0;
        end else begin
            dup_err_q <= dup_err_d;
        end
    end

    assign dup_err = dup_err_q;
`else
    assign dup_err = 1'b0;
`endif

    // Read ports: both return 0 for an index outside the matrix.
    always_comb begin
        current_element = '0;
        if (({1'b0, cur_i} < M_EXT) && ({1'b0, cur_j} < M_EXT)) begin
            current_element = mem_q[cur_i][cur_j];
        end
    end

    always_comb begin
        r_value = '0;
        if ((r_i < M_EXT) && (r_j < M_EXT)) begin
            r_value = mem_q[r_i[m_len-1:0]][r_j[m_len-1:0]];
        end
    end

    assign z_ack   = (state_q == S_ACK);
    assign done    = (state_q == S_FULL);
    assign idx_err = idx_err_q;
    assign state_o = state_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT, m = 4 ----------------
  logic        start;
  logic [31:0] z_out;
  logic [1:0]  z_i, z_j;
  logic        z_stb;
  logic        z_ack;
  logic [1:0]  cur_i, cur_j;
  logic [31:0] current_element;
  logic [2:0]  r_i, r_j;
  logic [31:0] r_value;
  logic        done, idx_err, dup_err;
  logic [1:0]  state_o;
  logic [4:0]  count_o;

  result_collector #(.m(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .z_out(z_out), .z_i(z_i), .z_j(z_j), .z_stb(z_stb), .z_ack(z_ack),
    .cur_i(cur_i), .cur_j(cur_j), .current_element(current_element),
    .r_i(r_i), .r_j(r_j), .r_value(r_value),
    .done(done), .idx_err(idx_err), .dup_err(dup_err),
    .state_o(state_o), .count_o(count_o)
  );

  // ---------------- DUT, m = 3 (out-of-range index reachable) ----------------
  logic        start3;
  logic [31:0] z_out3;
  logic [1:0]  z_i3, z_j3;
  logic        z_stb3;
  logic        z_ack3;
  logic [1:0]  cur_i3, cur_j3;
  logic [31:0] current_element3;
  logic [2:0]  r_i3, r_j3;
  logic [31:0] r_value3;
  logic        done3, idx_err3, dup_err3;
  logic [1:0]  state3;
  logic [4:0]  count3;

  result_collector #(.m(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .z_out(z_out3), .z_i(z_i3), .z_j(z_j3), .z_stb(z_stb3), .z_ack(z_ack3),
    .cur_i(cur_i3), .cur_j(cur_j3), .current_element(current_element3),
    .r_i(r_i3), .r_j(r_j3), .r_value(r_value3),
    .done(done3), .idx_err(idx_err3), .dup_err(dup_err3),
    .state_o(state3), .count_o(count3)
  );

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_FULL = 2'd3;

`ifdef RESULT_COLLECTOR_DUP_DETECT_EN
  localparam logic DUP_EXP = 1'b1;
`else
  localparam logic DUP_EXP = 1'b0;
`endif

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // One producer transaction: raise z_stb, wait (bounded) for z_ack,
  // drop z_stb, and require z_ack to be gone the next cycle.
  task automatic do_write(input logic [1:0] i, input logic [1:0] j, input logic [31:0] v);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    z_i = i; z_j = j; z_out = v; z_stb = 1'b1;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (z_ack === 1'b1) seen = 1'b1;
    end
    z_stb = 1'b0;
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL ack_wait[%0d][%0d]: z_ack not seen in 8 cycles, required 1", i, j);
    end
    @(negedge clk);
    n_vec++;
    if (z_ack !== 1'b0) begin
      n_err++;
      $display("FAIL ack_pulse[%0d][%0d]: z_ack=%b, required 0", i, j, z_ack);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_vec++; if (state_o !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", state_o, S_IDLE); end
    n_vec++; if (z_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b, required 0", z_ack); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", done); end
    n_vec++; if (idx_err !== 1'b0 || dup_err !== 1'b0) begin n_err++; $display("FAIL reset_errs: idx=%b dup=%b, required 0 0", idx_err, dup_err); end
    n_vec++; if (count_o !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d, required 0", count_o); end
    n_vec++; if (r_value !== 32'd0) begin n_err++; $display("FAIL reset_rvalue: got %0d, required 0", r_value); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Strobe in IDLE without start is ignored.
    z_i = 2'd0; z_j = 2'd0; z_out = 32'd99; z_stb = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (z_ack !== 1'b0 || state_o !== S_IDLE) begin n_err++; $display("FAIL idle_ignore: ack=%b state=%0d, required 0 %0d", z_ack, state_o, S_IDLE); end
    z_stb = 1'b0;
  endtask

  task automatic test_fill();
    do_start();
    @(negedge clk);
    n_vec++; if (state_o !== S_COLLECT) begin n_err++; $display("FAIL fill_collect: state=%0d, required %0d", state_o, S_COLLECT); end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        do_write(2'(i), 2'(j), 32'(i * 4 + j));
        if (i == 3 && j == 2) begin
          n_vec++; if (done !== 1'b0 || count_o !== 5'd15) begin n_err++; $display("FAIL fill_15: done=%b count=%0d, required 0 15", done, count_o); end
        end
      end
    end
    n_vec++; if (done !== 1'b1 || state_o !== S_FULL) begin n_err++; $display("FAIL fill_done: done=%b state=%0d, required 1 %0d", done, state_o, S_FULL); end
    n_vec++; if (count_o !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d, required 16", count_o); end
    r_i = 3'd2; r_j = 3'd3; #1;
    n_vec++; if (r_value !== 32'd11) begin n_err++; $display("FAIL rvalue_2_3: got %0d, required 11", r_value); end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r_i = 3'(i); r_j = 3'(j); #1;
        n_vec++; if (r_value !== 32'(i * 4 + j)) begin n_err++; $display("FAIL rvalue[%0d][%0d]: got %0d, required %0d", i, j, r_value, i * 4 + j); end
      end
    end
    r_i = 3'd4; r_j = 3'd1; #1;
    n_vec++; if (r_value !== 32'd0) begin n_err++; $display("FAIL rvalue_oob: got %0d, required 0", r_value); end
    cur_i = 2'd3; cur_j = 2'd1; #1;
    n_vec++; if (current_element !== 32'd13) begin n_err++; $display("FAIL cur_3_1: got %0d, required 13", current_element); end
    // FULL: strobes are not acknowledged and contents stay frozen.
    @(negedge clk);
    z_i = 2'd3; z_j = 2'd1; z_out = 32'hDEAD; z_stb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++; if (z_ack !== 1'b0) begin n_err++; $display("FAIL full_noack: cycle %0d ack=%b, required 0", k, z_ack); end
    end
    z_stb = 1'b0;
    n_vec++; if (current_element !== 32'd13 || done !== 1'b1) begin n_err++; $display("FAIL full_frozen: cur=%0d done=%b, required 13 1", current_element, done); end
  endtask

  task automatic test_held_strobe();
    do_start();
    @(negedge clk);
    n_vec++; if (done !== 1'b0 || count_o !== 5'd0) begin n_err++; $display("FAIL restart_clear: done=%b count=%0d, required 0 0", done, count_o); end
    r_i = 3'd2; r_j = 3'd3; #1;
    n_vec++; if (r_value !== 32'd0) begin n_err++; $display("FAIL restart_mem: got %0d, required 0", r_value); end
    z_i = 2'd0; z_j = 2'd0; z_out = 32'd42; z_stb = 1'b1;
    @(negedge clk);
    n_vec++; if (z_ack !== 1'b1) begin n_err++; $display("FAIL held_ack1: got %b, required 1", z_ack); end
    @(negedge clk);
    n_vec++; if (z_ack !== 1'b0) begin n_err++; $display("FAIL held_ack2: got %b, required 0", z_ack); end
    z_stb = 1'b0;
    repeat (3) @(negedge clk);
    cur_i = 2'd0; cur_j = 2'd0; #1;
    n_vec++; if (current_element !== 32'd42 || count_o !== 5'd1) begin n_err++; $display("FAIL held_result: cur=%0d count=%0d, required 42 1", current_element, count_o); end
  endtask

  task automatic test_dup();
    pulse_reset();
    do_start();
    do_write(2'd1, 2'd1, 32'd5);
    n_vec++; if (dup_err !== 1'b0 || count_o !== 5'd1) begin n_err++; $display("FAIL dup_first: dup=%b count=%0d, required 0 1", dup_err, count_o); end
    do_write(2'd1, 2'd1, 32'd9);
    cur_i = 2'd1; cur_j = 2'd1; #1;
    n_vec++; if (current_element !== 32'd9) begin n_err++; $display("FAIL dup_value: got %0d, required 9", current_element); end
    n_vec++; if (count_o !== 5'd1) begin n_err++; $display("FAIL dup_count: got %0d, required 1", count_o); end
    n_vec++; if (dup_err !== DUP_EXP) begin n_err++; $display("FAIL dup_flag: got %b, required %b", dup_err, DUP_EXP); end
  endtask

  task automatic test_idx_err();
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    @(negedge clk);
    z_i3 = 2'd3; z_j3 = 2'd0; z_out3 = 32'd7; z_stb3 = 1'b1;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (z_ack3 === 1'b1) seen = 1'b1;
    end
    z_stb3 = 1'b0;
    n_vec++; if (!seen) begin n_err++; $display("FAIL idx_ack: z_ack not seen in 8 cycles, required 1"); end
    @(negedge clk);
    n_vec++; if (z_ack3 !== 1'b0) begin n_err++; $display("FAIL idx_ack_pulse: got %b, required 0", z_ack3); end
    n_vec++; if (idx_err3 !== 1'b1) begin n_err++; $display("FAIL idx_flag: got %b, required 1", idx_err3); end
    n_vec++; if (count3 !== 5'd0) begin n_err++; $display("FAIL idx_count: got %0d, required 0", count3); end
    r_i3 = 3'd3; r_j3 = 3'd0; #1;
    n_vec++; if (r_value3 !== 32'd0) begin n_err++; $display("FAIL idx_rvalue: got %0d, required 0", r_value3); end
    n_vec++; if (state3 !== S_COLLECT) begin n_err++; $display("FAIL idx_state: got %0d, required %0d", state3, S_COLLECT); end
  endtask

  task automatic test_reset_mid_ack();
    bit seen;
    seen = 1'b0;
    pulse_reset();
    do_start();
    for (int n = 0; n < 6; n++) do_write(2'(n / 4), 2'(n % 4), 32'(100 + n));
    r_i = 3'd1; r_j = 3'd1; #1;
    n_vec++; if (r_value !== 32'd105) begin n_err++; $display("FAIL pre_rst_value: got %0d, required 105", r_value); end
    @(negedge clk);
    z_i = 2'd2; z_j = 2'd0; z_out = 32'd77; z_stb = 1'b1;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (z_ack === 1'b1) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL rst_ack_wait: z_ack not seen in 8 cycles, required 1"); end
    rst = 1'b1; #1;
    n_vec++; if (z_ack !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_async: ack=%b done=%b, required 0 0", z_ack, done); end
    n_vec++; if (state_o !== S_IDLE || count_o !== 5'd0) begin n_err++; $display("FAIL rst_state: state=%0d count=%0d, required %0d 0", state_o, count_o, S_IDLE); end
    for (int n = 0; n < 7; n++) begin
      r_i = 3'(n / 4); r_j = 3'(n % 4); #1;
      n_vec++; if (r_value !== 32'd0) begin n_err++; $display("FAIL rst_clear[%0d][%0d]: got %0d, required 0", n / 4, n % 4, r_value); end
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++; if (z_ack !== 1'b0) begin n_err++; $display("FAIL post_rst_noack: cycle %0d ack=%b, required 0", k, z_ack); end
    end
    z_stb = 1'b0;
  endtask

  // ---------------- sequencer / report ----------------
  initial begin
    start = 1'b0; z_out = '0; z_i = '0; z_j = '0; z_stb = 1'b0;
    cur_i = '0; cur_j = '0; r_i = '0; r_j = '0;
    start3 = 1'b0; z_out3 = '0; z_i3 = '0; z_j3 = '0; z_stb3 = 1'b0;
    cur_i3 = '0; cur_j3 = '0; r_i3 = '0; r_j3 = '0;
    test_reset();
    test_fill();
    test_held_strobe();
    test_dup();
    test_idx_err();
    test_reset_mid_ack();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
